// File: rtl/truncate_if.sv
// Sample bus for the truncate width reducer: wide input word and registered narrow result.
interface truncate_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 18
);
  logic signed [IN_WIDTH-1:0]  value;
  logic signed [OUT_WIDTH-1:0] trunc_value;

  modport master (output value, input  trunc_value);
  modport slave  (input  value, output trunc_value);
endinterface

// File: rtl/truncate.sv
// Registered fixed-point width reducer: drops the low IN_FRAC-OUT_FRAC fraction bits,
// by floor truncation or by round-half-up with positive saturation.
module truncate #(
  parameter int IN_WIDTH   = 32,
  parameter int IN_FRAC    = 28,
  parameter int OUT_WIDTH  = 18,
  parameter int OUT_FRAC   = 14,
  parameter int ROUND_MODE = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  truncate_if.slave bus
);
  localparam int D = IN_FRAC - OUT_FRAC;

  if ((IN_WIDTH - IN_FRAC) != (OUT_WIDTH - OUT_FRAC)) begin : g_bad_int_bits
    $error("truncate: integer bit count must be preserved");
  end
  if (IN_FRAC <= OUT_FRAC) begin : g_bad_frac_bits
    $error("truncate: IN_FRAC must exceed OUT_FRAC");
  end
  if (ROUND_MODE != 0 && ROUND_MODE != 1) begin : g_bad_mode
    $error("truncate: ROUND_MODE must be 0 or 1");
  end

  localparam logic signed [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  logic signed [OUT_WIDTH-1:0] shifted;
  logic signed [OUT_WIDTH:0]   sum;
  logic signed [OUT_WIDTH-1:0] next_value;

  always_comb begin
    shifted    = bus.value[IN_WIDTH-1:D];
    sum        = {shifted[OUT_WIDTH-1], shifted} + {{OUT_WIDTH{1'b0}}, bus.value[D-1]};
    next_value = shifted;
    if (ROUND_MODE == 1) begin
      // Only a positive carry into the sign bit can overflow; negative sums stay in range.
      if (!sum[OUT_WIDTH] && sum[OUT_WIDTH-1]) begin
        next_value = MAX_POS;
      end else begin
        next_value = sum[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.trunc_value <= '0;
    end else begin
      bus.trunc_value <= next_value;
    end
  end
endmodule

// File: tb/tb_truncate.sv
// Directed bench for truncate: one instance per ROUND_MODE, both fed the same sample.
module tb_truncate;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [31:0] tv = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  truncate_if #(.IN_WIDTH(32), .OUT_WIDTH(18)) bus_t ();
  truncate_if #(.IN_WIDTH(32), .OUT_WIDTH(18)) bus_r ();
  assign bus_t.value = tv;
  assign bus_r.value = tv;

  truncate #(.IN_WIDTH(32), .IN_FRAC(28), .OUT_WIDTH(18), .OUT_FRAC(14), .ROUND_MODE(0))
    dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));
  truncate #(.IN_WIDTH(32), .IN_FRAC(28), .OUT_WIDTH(18), .OUT_FRAC(14), .ROUND_MODE(1))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, check just after the next rising edge.
  task automatic step(input logic [31:0] v, input logic [17:0] exp_t,
                      input logic [17:0] exp_r, input string tag);
    @(negedge clk);
    tv = v;
    @(posedge clk);
    #1;
    check({tag, "/trunc"}, bus_t.trunc_value, exp_t);
    check({tag, "/round"}, bus_r.trunc_value, exp_r);
  endtask

  typedef struct {
    logic [31:0] v;
    logic [17:0] et;
    logic [17:0] er;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Reset held low with a toggling input: outputs stay zero.
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      tv = (i % 2 == 0) ? 32'h0555_5555 : 32'h0000_0000;
      @(posedge clk);
      #1;
      check("reset_t", bus_t.trunc_value, 18'h00000);
      check("reset_r", bus_r.trunc_value, 18'h00000);
    end
    @(negedge clk);
    tv = 32'h0555_5555;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_t", bus_t.trunc_value, 18'h01555);
    check("release_r", bus_r.trunc_value, 18'h01555);

    // Back-to-back vectors, plus a mid-cycle stability check before each new drive.
    vecs.push_back('{32'hFAAA_AAAB, 18'h3EAAA, 18'h3EAAB});
    vecs.push_back('{32'hF5E8_BCB6, 18'h3D7A2, 18'h3D7A3});
    vecs.push_back('{32'h0555_5555, 18'h01555, 18'h01555});
    vecs.push_back('{32'h08E3_8E39, 18'h0238E, 18'h0238E});
    vecs.push_back('{32'h096A_BC51, 18'h025AA, 18'h025AB});
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].et, vecs[i].er, "pipe");
      @(negedge clk);
      check("hold_t", bus_t.trunc_value, vecs[i].et);
    end

    // Extremes and rounding boundaries.
    step(32'h7FFF_FFFF, 18'h1FFFF, 18'h1FFFF, "maxpos");
    step(32'h8000_0000, 18'h20000, 18'h20000, "maxneg");
    step(32'hFFFF_FFFF, 18'h3FFFF, 18'h00000, "minus1");
    step(32'h0000_3FFF, 18'h00000, 18'h00001, "sub_lsb");
    step(32'h0000_2000, 18'h00000, 18'h00001, "half");
    step(32'h0000_1FFF, 18'h00000, 18'h00000, "below_half");
    step(32'hFFFF_E000, 18'h3FFFF, 18'h00000, "neg_half");

    // Input change between edges must not reach the output.
    @(negedge clk);
    tv = 32'h0555_5555;
    @(posedge clk);
    #2;
    tv = 32'h8000_0000;
    #1;
    check("no_glitch", bus_t.trunc_value, 18'h01555);

    // Asynchronous reset mid-stream, then recapture on the first edge after release.
    rst_n = 1'b0;
    #1;
    check("async_rst_t", bus_t.trunc_value, 18'h00000);
    check("async_rst_r", bus_r.trunc_value, 18'h00000);
    @(posedge clk);
    #1;
    check("rst_hold", bus_t.trunc_value, 18'h00000);
    @(negedge clk);
    tv = 32'h096A_BC51;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("recapture_t", bus_t.trunc_value, 18'h025AA);
    check("recapture_r", bus_r.trunc_value, 18'h025AB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
